// File: rtl/melody_sequencer.sv
`timescale 1ns/1ps
// Melody sequencer: walks a note memory and drives a square-wave tone generator,
// timing each note and the silent gap after it, with pause, stop and looping.
module melody_sequencer #(
    parameter int CLK_PERIOD_NS = 10,
    parameter int TICK_CYCLES   = 100000,
    parameter int GAP_TICKS     = 10,
    parameter int ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [47:0]       mem_rdata,
    output logic [31:0]       period,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // The clock period is informational only; reject nonsensical settings at elaboration.
    if (CLK_PERIOD_NS < 1 || TICK_CYCLES < 1 || GAP_TICKS < 0) begin : g_bad_params
        $error("melody_sequencer: illegal parameter setting");
    end

    logic [2:0]        state_r;
    logic [ADDR_W-1:0] base_addr_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_rd_r;
    logic [31:0]       period_r;
    logic              tone_en_r;
    logic              busy_r;
    logic              done_r;
    logic [TW-1:0]     tick_cnt_r;
    logic [15:0]       dur_cnt_r;
    logic [GW-1:0]     gap_cnt_r;

    logic              tick_wrap_s;
    logic [15:0]       note_dur_s;
    logic [31:0]       note_period_s;
    logic [ADDR_W-1:0] next_addr_s;

    assign tick_wrap_s   = (tick_cnt_r == TICK_LAST);
    assign note_dur_s    = mem_rdata[47:32];
    assign note_period_s = mem_rdata[31:0];
    assign next_addr_s   = mem_addr_r + ADDR_W'(1'b1);

    assign mem_addr = mem_addr_r;
    assign mem_rd   = mem_rd_r;
    assign period   = period_r;
    assign tone_en  = tone_en_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Sequencer state, note timing and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            base_addr_r <= '0;
            mem_addr_r  <= '0;
            mem_rd_r    <= 1'b0;
            period_r    <= 32'd0;
            tone_en_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            tick_cnt_r  <= '0;
            dur_cnt_r   <= 16'd0;
            gap_cnt_r   <= '0;
        end else if (stop) begin
            state_r    <= ST_IDLE;
            mem_rd_r   <= 1'b0;
            period_r   <= 32'd0;
            tone_en_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            tick_cnt_r <= '0;
            dur_cnt_r  <= 16'd0;
            gap_cnt_r  <= '0;
        end else begin
            mem_rd_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        base_addr_r <= start_addr;
                        mem_addr_r  <= start_addr;
                        mem_rd_r    <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_FETCH;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (note_dur_s == 16'd0) begin
                        if (loop) begin
                            mem_addr_r <= base_addr_r;
                            mem_rd_r   <= 1'b1;
                            state_r    <= ST_FETCH;
                        end else begin
                            done_r    <= 1'b1;
                            tone_en_r <= 1'b0;
                            period_r  <= 32'd0;
                            state_r   <= ST_DONE;
                        end
                    end else begin
                        period_r   <= note_period_s;
                        dur_cnt_r  <= note_dur_s;
                        tick_cnt_r <= '0;
                        tone_en_r  <= (note_period_s != 32'd0);
                        state_r    <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    // While paused all counters hold, so the note resumes with its exact remainder.
                    if (pause) begin
                        tone_en_r <= 1'b0;
                    end else if (!tick_wrap_s) begin
                        tick_cnt_r <= tick_cnt_r + TW'(1'b1);
                        tone_en_r  <= (period_r != 32'd0);
                    end else begin
                        tick_cnt_r <= '0;
                        if (dur_cnt_r == 16'd1) begin
                            dur_cnt_r <= 16'd0;
                            tone_en_r <= 1'b0;
                            if (GAP_TICKS > 0) begin
                                gap_cnt_r <= GAP_LOAD;
                                state_r   <= ST_GAP;
                            end else begin
                                mem_addr_r <= next_addr_s;
                                mem_rd_r   <= 1'b1;
                                state_r    <= ST_FETCH;
                            end
                        end else begin
                            dur_cnt_r <= dur_cnt_r - 16'd1;
                            tone_en_r <= (period_r != 32'd0);
                        end
                    end
                end
                ST_GAP: begin
                    tone_en_r <= 1'b0;
                    if (pause) begin
                        gap_cnt_r <= gap_cnt_r;
                    end else if (!tick_wrap_s) begin
                        tick_cnt_r <= tick_cnt_r + TW'(1'b1);
                    end else begin
                        tick_cnt_r <= '0;
                        gap_cnt_r  <= gap_cnt_r - GW'(1'b1);
                        if (gap_cnt_r == GW'(1'b1)) begin
                            mem_addr_r <= next_addr_s;
                            mem_rd_r   <= 1'b1;
                            state_r    <= ST_FETCH;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    tone_en_r <= 1'b0;
                    period_r  <= 32'd0;
                    busy_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Plays a melody stored in a note memory by sequencing the team's square-wave tone generator. Each note-memory entry gives a tone period in ns and a duration in ticks. The block drives the tone generator's period and enable inputs and times each note and an inter-note gap. It also handles start, stop, pause, looping and end-of-melody detection. It sits between the top-level control logic (buttons, song select) and the tone generator / memory.

Parameters:
CLK_PERIOD_NS, 10, system clock period in ns; informational, must match the tone generator's clock-period setting.
TICK_CYCLES, 100000, clock cycles per duration tick (1 ms at 100 MHz); legal range is 1 or greater.
GAP_TICKS, 10, silent ticks inserted after every note; 0 means no gap.
ADDR_W, 8, note-memory address width.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active-low.
start  input  1  level-sampled; starts playback when the block is idle.
stop  input  1  aborts playback; has priority over every other input.
pause  input  1  level; freezes playback while high.
loop  input  1  level, sampled at end-of-melody; restarts from start_addr when high.
start_addr  input  ADDR_W  first entry; latched when start is accepted.
mem_addr  output  ADDR_W  note-memory read address.
mem_rd  output  1  read strobe, high for exactly one cycle per fetch.
mem_rdata  input  48  read data, valid the cycle after mem_rd. Bits [47:32] are the duration in ticks (0 = end marker). Bits [31:0] are the period in ns (0 = rest).
period  output  32  to tone generator period input.
tone_en  output  1  to tone generator enable input.
busy  output  1  high whenever state is not IDLE.
done  output  1  one-cycle pulse on natural end of melody.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; period=0, tone_en=0, mem_addr=0, mem_rd=0, busy=0, done=0; tick and duration counters 0.
- States: IDLE, FETCH, LOAD, PLAY, GAP, DONE. All outputs are registered.
- IDLE: start=1 and stop=0 → latch start_addr into base_addr and mem_addr, go to FETCH. start is ignored in all other states.
- FETCH: mem_rd=1 for this single cycle; next state is LOAD.
- LOAD: sample mem_rdata.
  - If duration==0 and loop=1: mem_addr←base_addr, go to FETCH.
  - If duration==0 and loop=0: go to DONE.
  - Otherwise: period←rdata[31:0], dur_cnt←duration, tick_cnt←0, tone_en←(rdata[31:0]!=0), go to PLAY.
- PLAY:
  - tick_cnt counts 0..TICK_CYCLES-1 and wraps; each wrap decrements dur_cnt.
  - A wrap with dur_cnt==1 ends the note: tone_en←0, period holds.
  - At note end: if GAP_TICKS>0, load gap_cnt←GAP_TICKS and go to GAP. Else mem_addr←mem_addr+1 and go to FETCH.
  - tone_en is high for exactly duration×TICK_CYCLES cycles, starting the cycle after LOAD. It stays 0 throughout for a rest.
- GAP: tone_en=0; same tick timing. After GAP_TICKS×TICK_CYCLES cycles: mem_addr←mem_addr+1, go to FETCH.
- Address increment wraps from 2^ADDR_W−1 to 0 with no error.
- Start latency: start sampled at edge k → FETCH in cycle k+1, LOAD in k+2, tone_en=1 from k+3.
- Note-to-note overhead: 2 extra cycles with tone_en=0 (FETCH + LOAD), on top of the gap.
- DONE: done=1 for one cycle, tone_en=0, period=0; next state IDLE.
- pause=1 in PLAY or GAP:
  - tick_cnt, dur_cnt and gap_cnt freeze; tone_en is forced 0.
  - On release, the remaining time resumes exactly and tone_en restores to (period!=0).
  - pause during FETCH/LOAD does not stall them; the freeze takes effect on entering PLAY.
- stop=1 in any state: next state IDLE; tone_en=0, period=0, mem_rd=0, counters cleared; no done pulse. stop together with start in IDLE: stays IDLE.
- rst_n=0 mid-note: same as the reset values, regardless of state.
- Widths: tick_cnt must be wide enough for TICK_CYCLES−1. dur_cnt is 16 bits. gap_cnt must be wide enough for GAP_TICKS.

Test Plan:
(TICK_CYCLES=4, GAP_TICKS=1, ADDR_W=4 unless stated.)
1. Memory {0: dur 2/period 1000, 1: dur 0}, start_addr=0, loop=0, start pulse at edge 0 → mem_rd high in cycle 1 (addr 0) and cycle 15 (addr 1). tone_en high cycles 3–10 with period=1000. done pulse in cycle 17, then busy=0.
2. Rest entry {0: dur 1/period 0, 1: dur 0} → tone_en never asserts; done arrives after 4+4+2 cycles of PLAY/GAP/FETCH/LOAD plus the initial start latency.
3. loop=1 with the memory of test 1 → after the end marker, mem_addr returns to 0 without a done pulse. The second note starts 2 cycles after the marker LOAD; busy stays 1.
4. pause high for 7 cycles starting in cycle 5 of a dur-2 note → tone_en low during the pause. Total tone_en high time stays 8 cycles; the note ends 7 cycles later than in test 1.
5. stop asserted in cycle 6 during PLAY, together with start → cycle 7: IDLE, tone_en=0, period=0, done=0. A later start plays again from start_addr.
6. start_addr=15 with entry 15 a note and entry 0 the end marker → after note 15, mem_addr wraps to 0. rst_n=0 mid-note clears all outputs on the next edge.
